freq_cmd_decoder: RTL and testbench

FREQ_CMD_DECODER -- requirements
Module: freq_cmd_decoder

---
 rtl/freq_cmd_pkg.sv | 18 +
 rtl/freq_cmd_timeout.sv | 34 +++
 rtl/freq_cmd_decoder.sv | 159 +++++++++++++++
 tb/tb_freq_cmd_decoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_cmd_pkg.sv
// Shared constants and FSM encoding for the frequency command decoder.
// The CSUM state exists only when FREQ_CMD_CHECKSUM_EN is defined.
package freq_cmd_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hFF;
   localparam logic [7:0] TRL_BYTE = 8'hFE;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CHAN = 3'd1,
      DATA = 3'd2,
`ifdef FREQ_CMD_CHECKSUM_EN
      CSUM = 3'd3,
`endif
      TAIL = 3'd4
   } state_t;

endpackage

// File: rtl/freq_cmd_timeout.sv
// Inter-byte watchdog: counts cycles without a kick while a frame is open and
// flags expiry on the TIMEOUT_CYC-th consecutive quiet cycle.
module freq_cmd_timeout #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic kick,
   input  logic active,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      expired = active && !kick && (cnt_q == LAST);
      cnt_d   = cnt_q + 1'b1;
      if (kick || !active || expired) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/freq_cmd_decoder.sv
// Byte-stream frame decoder that commits frequency words into per-channel registers.
// Optional trailing XOR checksum byte is enabled with FREQ_CMD_CHECKSUM_EN.
module freq_cmd_decoder
   import freq_cmd_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int FREQ_W      = 28,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               data_input,
   input  logic                     rx_valid,
   output logic [N_CH*FREQ_W-1:0]   freq_out,
   output logic                     set_flag,
   output logic [3:0]               set_ch,
   output logic                     frame_err
);

   localparam int NB   = (FREQ_W + 7) / 8;
   localparam int SH_W = NB * 8;
   localparam int FO_W = N_CH * FREQ_W;
   localparam logic [7:0] NCH_B  = 8'(N_CH);
   localparam logic [2:0] LAST_B = 3'(NB - 1);

   state_t            state_q, state_d;
   logic [SH_W-1:0]   shift_q, shift_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [3:0]        ch_q, ch_d;
   logic [FO_W-1:0]   freq_q, freq_d;
   logic [3:0]        set_ch_q, set_ch_d;
   logic              set_flag_q, set_flag_d;
   logic              frame_err_q, frame_err_d;
`ifdef FREQ_CMD_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif
   logic              expired;

   freq_cmd_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .kick   (rx_valid),
      .active (state_q != IDLE),
      .expired(expired)
   );

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      ch_d        = ch_q;
      freq_d      = freq_q;
      set_ch_d    = set_ch_q;
      set_flag_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef FREQ_CMD_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      if (expired) begin
         frame_err_d = 1'b1;
         state_d     = IDLE;
      end else if (rx_valid) begin
         case (state_q)
            IDLE: begin
               if (data_input == HDR_BYTE) begin
                  state_d = CHAN;
                  shift_d = '0;
                  cnt_d   = '0;
`ifdef FREQ_CMD_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end
            CHAN: begin
               if (data_input < NCH_B) begin
                  ch_d    = data_input[3:0];
                  state_d = DATA;
`ifdef FREQ_CMD_CHECKSUM_EN
                  csum_d  = data_input;
`endif
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end
            end
            DATA: begin
               // Payload is literal: a 0xFF here is data, never a new header.
               shift_d = SH_W'({shift_q, data_input});
               cnt_d   = cnt_q + 3'd1;
`ifdef FREQ_CMD_CHECKSUM_EN
               csum_d  = csum_q ^ data_input;
               if (cnt_q == LAST_B) state_d = CSUM;
`else
               if (cnt_q == LAST_B) state_d = TAIL;
`endif
            end
`ifdef FREQ_CMD_CHECKSUM_EN
            CSUM: begin
               if (data_input == csum_q) begin
                  state_d = TAIL;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end
            end
`endif
            TAIL: begin
               if (data_input == TRL_BYTE) begin
                  for (int k = 0; k < N_CH; k++) begin
                     if (ch_q == 4'(k)) freq_d[k*FREQ_W +: FREQ_W] = shift_q[FREQ_W-1:0];
                  end
                  set_flag_d = 1'b1;
                  set_ch_d   = ch_q;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         ch_q        <= '0;
         freq_q      <= '0;
         set_ch_q    <= '0;
         set_flag_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef FREQ_CMD_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         freq_q      <= freq_d;
         set_ch_q    <= set_ch_d;
         set_flag_q  <= set_flag_d;
         frame_err_q <= frame_err_d;
`ifdef FREQ_CMD_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign freq_out  = freq_q;
   assign set_flag  = set_flag_q;
   assign set_ch    = set_ch_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_freq_cmd_decoder.sv
// Scoreboard bench for freq_cmd_decoder: a byte-position reference model queues
// expected commit/error events; a negedge monitor checks them. Honours FREQ_CMD_CHECKSUM_EN.
module tb_freq_cmd_decoder;

   localparam int N_CH = 4;
   localparam int FREQ_W = 28;
   localparam int TCYC = 64;
   localparam int NB = (FREQ_W + 7) / 8;
   localparam int FO_W = N_CH * FREQ_W;
`ifdef FREQ_CMD_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [7:0]      data_input = 8'h00;
   logic            rx_valid = 1'b0;
   logic [FO_W-1:0] freq_out;
   logic            set_flag;
   logic [3:0]      set_ch;
   logic            frame_err;

   freq_cmd_decoder #(
      .N_CH(N_CH), .FREQ_W(FREQ_W), .TIMEOUT_CYC(TCYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_input(data_input), .rx_valid(rx_valid),
      .freq_out(freq_out), .set_flag(set_flag), .set_ch(set_ch), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit              is_err;
      int              cyc;
      logic [3:0]      ch;
      logic [FO_W-1:0] f;
   } exp_t;
   exp_t expq[$];

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: frame position since header, accumulated value, XOR.
   logic [FREQ_W-1:0] mf [N_CH];
   logic [3:0]        m_last_ch = 4'd0;
   bit                in_frame = 1'b0;
   int                pos = 0;
   int                m_ch = 0;
   longint            acc = 0;
   logic [7:0]        xs = 8'h00;
   int                last_rx_cyc = 0;

   function automatic logic [FO_W-1:0] pack_model();
      logic [FO_W-1:0] v;
      for (int k = 0; k < N_CH; k++) v[k*FREQ_W +: FREQ_W] = mf[k];
      return v;
   endfunction

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push_exp(bit e, int c);
      exp_t x;
      x.is_err = e;
      x.cyc    = c;
      x.ch     = m_last_ch;
      x.f      = pack_model();
      expq.push_back(x);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < N_CH; k++) mf[k] = '0;
      m_last_ch = 4'd0;
      in_frame = 1'b0;
      expq.delete();
   endfunction

   function automatic void model_byte(logic [7:0] b, int c);
      last_rx_cyc = c;
      if (!in_frame) begin
         if (b == 8'hFF) begin
            in_frame = 1'b1;
            pos = 0;
         end
         return;
      end
      pos++;
      if (pos == 1) begin
         if (int'(b) >= N_CH) begin
            in_frame = 1'b0;
            push_exp(1'b1, c);
         end else begin
            m_ch = int'(b);
            acc = 0;
            xs = b;
         end
      end else if (pos <= 1 + NB) begin
         acc = acc * 256 + longint'(b);
         xs = xs ^ b;
      end else if (CS == 1 && pos == 2 + NB) begin
         if (b != xs) begin
            in_frame = 1'b0;
            push_exp(1'b1, c);
         end
      end else begin
         in_frame = 1'b0;
         if (b == 8'hFE) begin
            mf[m_ch] = FREQ_W'(acc % (longint'(1) << FREQ_W));
            m_last_ch = 4'(m_ch);
            push_exp(1'b0, c);
         end else begin
            push_exp(1'b1, c);
         end
      end
   endfunction

   task automatic send(input logic [7:0] b);
      data_input = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      model_byte(b, cyc);
   endtask

   task automatic idle(input int n);
      if (in_frame && n >= TCYC) begin
         in_frame = 1'b0;
         push_exp(1'b1, last_rx_cyc + TCYC);
      end
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int ch, input logic [31:0] val, input logic [7:0] trl,
                             input logic [7:0] cs_flip, input int maxgap);
      logic [7:0] q[$];
      logic [7:0] x;
      q.push_back(8'hFF);
      q.push_back(8'(ch));
      x = 8'(ch);
      for (int i = NB - 1; i >= 0; i--) begin
         q.push_back(val[8*i +: 8]);
         x = x ^ val[8*i +: 8];
      end
      if (CS == 1) q.push_back(x ^ cs_flip);
      q.push_back(trl);
      foreach (q[i]) begin
         send(q[i]);
         if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
   endtask

   // Monitor: every set_flag/frame_err pulse must match the oldest queued event.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (expq.size() > 0 && expq[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got none expected %s at cycle %0d (now %0d)",
                     expq[0].is_err ? "frame_err" : "set_flag", expq[0].cyc, cyc);
            void'(expq.pop_front());
         end
         if (set_flag || frame_err) begin
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_event: got set_flag=%0b frame_err=%0b expected none (cycle %0d)",
                        set_flag, frame_err, cyc);
            end else begin
               e = expq.pop_front();
               chk("event_cycle", 128'(cyc), 128'(e.cyc));
               chk("set_flag", 128'(set_flag), 128'(!e.is_err));
               chk("frame_err", 128'(frame_err), 128'(e.is_err));
               chk("set_ch", 128'(set_ch), 128'(e.ch));
               chk("freq_out", 128'(freq_out), 128'(e.f));
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of test expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("reset_freq_out", 128'(freq_out), 128'd0);
      chk("reset_set_flag", 128'(set_flag), 128'd0);
      chk("reset_frame_err", 128'(frame_err), 128'd0);
      chk("reset_set_ch", 128'(set_ch), 128'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      // Basic commit to channel 1 with one-cycle latency
      send_frame(1, 32'h01234567, 8'hFE, 8'h00, 0);
      chk("commit_set_flag_now", 128'(set_flag), 128'd1);
      chk("commit_ch1_value", 128'(freq_out[1*FREQ_W +: FREQ_W]), 128'h1234567);
      chk("commit_other_ch", 128'(freq_out & ~({{(FO_W-FREQ_W){1'b0}}, {FREQ_W{1'b1}}} << FREQ_W)), 128'd0);
      idle(1);
      chk("commit_set_flag_drop", 128'(set_flag), 128'd0);
      chk("commit_set_ch_hold", 128'(set_ch), 128'd1);

      // Bad channel, trailing junk ignored, then a good frame for channel 0
      send(8'hFF); send(8'h05);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'hFE);
      idle(2);
      chk("badch_freq_out", 128'(freq_out), 128'(pack_model()));
      send_frame(0, 32'h00ABCDEF, 8'hFE, 8'h00, 0);
      idle(2);

      // Wrong trailer leaves channel 2 untouched
      send(8'hFF); send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h10); send(8'hAA);
      idle(2);
      chk("badtrl_ch2", 128'(freq_out[2*FREQ_W +: FREQ_W]), 128'd0);

      // Timeout mid-payload, then recovery
      send(8'hFF); send(8'h00); send(8'h00); send(8'h00);
      idle(TCYC + 2);
      send_frame(0, 32'h0000000A, 8'hFE, 8'h00, 0);
      idle(1);
      chk("timeout_recover_ch0", 128'(freq_out[FREQ_W-1:0]), 128'hA);

`ifdef FREQ_CMD_CHECKSUM_EN
      send(8'hFF); send(8'h03); send(8'h00); send(8'h00); send(8'h01); send(8'h00); send(8'h02); send(8'hFE);
      idle(1);
      chk("csum_ok_ch3", 128'(freq_out[3*FREQ_W +: FREQ_W]), 128'h100);
      send(8'hFF); send(8'h03); send(8'h00); send(8'h00); send(8'h02); send(8'h00); send(8'h03); send(8'hFE);
      idle(2);
      chk("csum_bad_ch3", 128'(freq_out[3*FREQ_W +: FREQ_W]), 128'h100);
`endif

      // Reset mid-frame discards the partial frame
      send(8'hFF); send(8'h01); send(8'h00);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_freq_out", 128'(freq_out), 128'd0);
      chk("midrst_set_ch", 128'(set_ch), 128'd0);
      chk("midrst_set_flag", 128'(set_flag), 128'd0);
      chk("midrst_frame_err", 128'(frame_err), 128'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(8'h00); send(8'h00); send(8'hFE);
      idle(4);
      chk("midrst_after_tail", 128'(freq_out), 128'd0);

      // Randomized mix of good, corrupted, junk and timed-out traffic
      for (int it = 0; it < 200; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            send_frame($urandom_range(0, N_CH - 1), $urandom, 8'hFE, 8'h00,
                       ($urandom_range(0, 1) == 1) ? 2 : 0);
         end else if (r == 5) begin
            send(8'hFF);
            send(8'($urandom_range(N_CH, 255)));
         end else if (r == 6) begin
            send_frame($urandom_range(0, N_CH - 1), $urandom,
                       ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 253)) : 8'hFE,
                       (CS == 1) ? 8'($urandom_range(1, 255)) : 8'h00, 1);
         end else if (r == 7) begin
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) send(8'($urandom));
         end else if (r == 8) begin
            send(8'hFF);
            for (int j = 0; j < int'($urandom_range(0, NB)); j++) send(8'($urandom_range(0, N_CH - 1)));
            idle(TCYC + $urandom_range(0, 3));
         end else begin
            idle($urandom_range(0, 5));
         end
      end

      idle(TCYC + 4);
      chk("final_queue_empty", 128'(expq.size()), 128'd0);
      chk("final_freq_out", 128'(freq_out), 128'(pack_model()));
      chk("final_set_ch", 128'(set_ch), 128'(m_last_ch));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
